// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq
// Purpose  : Multicycle barrel-shift unit. Selects a shift amount from the
//            immediate shamt field, the low bits of the B operand register or
//            a fixed constant. Performs pass/sll/srl/sra/rol/ror STEP bit
//            positions per cycle under a start/done handshake.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            start      - request an operation (sampled in IDLE only)
//            abort      - cancel an in-flight operation
//            shamt_sel  - 00 imm_shamt, 01 reg_b low bits, 1x CONST_SHAMT
//            shift_op   - 000 pass, 001 sll, 010 srl, 011 sra, 100 rol,
//                         101 ror, 11x pass
//            data_in    - operand to shift
//            imm_shamt  - instruction shamt field
//            reg_b      - B operand register
//            busy       - high while not IDLE
//            done       - one-cycle completion pulse
//            result     - last completed result
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq #(
   parameter int WIDTH       = 32,
   parameter int SHAMT_W     = 5,
   parameter int STEP        = 1,
   parameter int CONST_SHAMT = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         shamt_sel,
   input  logic [2:0]         shift_op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] imm_shamt,
   input  logic [WIDTH-1:0]   reg_b,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_SRL = 3'b010;
   localparam logic [2:0] OP_SRA = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;

   localparam logic [SHAMT_W-1:0] STEP_AMT  = SHAMT_W'(STEP);
   localparam logic [SHAMT_W-1:0] CONST_AMT = SHAMT_W'(CONST_SHAMT);
   localparam logic [SHAMT_W:0]   WIDTH_AMT = (SHAMT_W+1)'(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   work;
   logic [2:0]         op_q;
   logic [SHAMT_W-1:0] rem;

   logic [SHAMT_W-1:0] amount;
   logic               start_pass;
   logic [SHAMT_W-1:0] step_amt;
   logic [SHAMT_W:0]   inv_amt;
   logic               last_step;
   logic [WIDTH-1:0]   shifted;

   // Only the low SHAMT_W bits of reg_b carry a shift amount.
   logic unused_reg_b_hi;
   assign unused_reg_b_hi = ^reg_b[WIDTH-1:SHAMT_W];

   // ------------------------------------------------------------------------
   // Amount selection and start classification
   // ------------------------------------------------------------------------
   always_comb begin
      amount = CONST_AMT;
      case (shamt_sel)
         2'b00:   amount = imm_shamt;
         2'b01:   amount = reg_b[SHAMT_W-1:0];
         default: amount = CONST_AMT;
      endcase
   end

   // Unused op codes and zero amounts complete straight from IDLE.
   assign start_pass = (amount == '0) || (shift_op == 3'b000) ||
                       (shift_op > OP_ROR);

   // ------------------------------------------------------------------------
   // One shift step: s = min(STEP, remaining)
   // ------------------------------------------------------------------------
   assign step_amt  = (rem < STEP_AMT) ? rem : STEP_AMT;
   // step_amt never reaches WIDTH, so the complementary rotate part is valid.
   assign inv_amt   = WIDTH_AMT - {1'b0, step_amt};
   assign last_step = (rem == step_amt);

   always_comb begin
      shifted = work;
      case (op_q)
         OP_SLL:  shifted = work << step_amt;
         OP_SRL:  shifted = work >> step_amt;
         // The MSB is never changed by sra, so it always holds the sign of
         // the original operand.
         OP_SRA:  shifted = $unsigned($signed(work) >>> step_amt);
         OP_ROL:  shifted = (work << step_amt) | (work >> inv_amt);
         OP_ROR:  shifted = (work >> step_amt) | (work << inv_amt);
         default: shifted = work;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = start_pass ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Abort wins over a completing final step.
            if (abort) begin
               state_nxt = IDLE;
            end else if (last_step) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work   <= '0;
         op_q   <= 3'b000;
         rem    <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  work <= data_in;
                  op_q <= shift_op;
                  rem  <= amount;
                  if (start_pass) begin
                     result <= data_in;
                  end
               end
            end
            SHIFT: begin
               if (!abort) begin
                  work <= shifted;
                  rem  <= rem - step_amt;
                  if (last_step) begin
                     result <= shifted;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq
// Purpose  : Scoreboard bench for shift_seq. Two instances share stimulus:
//            one with STEP = 1 and one with STEP = 4. Each expected result and
//            the edge number at which done must appear are queued per
//            instance; monitors pop and compare on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

   typedef struct {
      logic [31:0] res;
      int          edge_no;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [1:0]  shamt_sel;
   logic [2:0]  shift_op;
   logic [31:0] data_in;
   logic [4:0]  imm_shamt;
   logic [31:0] reg_b;

   logic        busy1, done1, busy4, done4;
   logic [31:0] result1, result4;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q1[$];
   exp_t q4[$];

   shift_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(1), .CONST_SHAMT(24)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .shamt_sel(shamt_sel), .shift_op(shift_op), .data_in(data_in),
      .imm_shamt(imm_shamt), .reg_b(reg_b),
      .busy(busy1), .done(done1), .result(result1)
   );

   shift_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4), .CONST_SHAMT(24)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .shamt_sel(shamt_sel), .shift_op(shift_op), .data_in(data_in),
      .imm_shamt(imm_shamt), .reg_b(reg_b),
      .busy(busy4), .done(done4), .result(result4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitors
   always @(negedge clk) begin
      if (rst_n && done1) begin
         exp_t e;
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step1 unexpected done at edge %0d", cyc);
         end else begin
            e = q1.pop_front();
            chk({e.name, " step1 result"}, result1, e.res);
            chk({e.name, " step1 done edge"}, 32'(cyc), 32'(e.edge_no));
         end
      end
      if (rst_n && done4) begin
         exp_t e;
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step4 unexpected done at edge %0d", cyc);
         end else begin
            e = q4.pop_front();
            chk({e.name, " step4 result"}, result4, e.res);
            chk({e.name, " step4 done edge"}, 32'(cyc), 32'(e.edge_no));
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic wait_idle(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy1 && !busy4) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s idle timeout: busy1=%0b busy4=%0b required 0", nm, busy1, busy4);
      end
   endtask

   // Issues one operation; start is held for 'hold' sampled edges while the
   // operand inputs are scrambled after the first edge.
   task automatic issue(input string nm, input logic [1:0] sel, input logic [2:0] op,
                        input logic [31:0] din, input logic [4:0] imm,
                        input logic [31:0] rb, input logic [31:0] exp_res,
                        input int n1, input int n4, input int hold);
      int e;
      @(negedge clk);
      shamt_sel = sel;
      shift_op  = op;
      data_in   = din;
      imm_shamt = imm;
      reg_b     = rb;
      start     = 1'b1;
      e = cyc + 1;
      q1.push_back('{exp_res, e + n1, nm});
      q4.push_back('{exp_res, e + n4, nm});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk({nm, " busy1 after start"}, {31'd0, busy1}, 32'd1);
            chk({nm, " busy4 after start"}, {31'd0, busy4}, 32'd1);
            data_in   = ~din;
            imm_shamt = ~imm;
            reg_b     = ~rb;
            shamt_sel = ~sel;
            shift_op  = 3'b001;
         end
      end
      start = 1'b0;
      wait_idle(nm);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      shamt_sel = 2'b00;
      shift_op  = 3'b000;
      data_in   = 32'h0;
      imm_shamt = 5'd0;
      reg_b     = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset busy1", {31'd0, busy1}, 32'd0);
      chk("reset done1", {31'd0, done1}, 32'd0);
      chk("reset result1", result1, 32'h0);
      chk("reset result4", result4, 32'h0);
      rst_n = 1'b1;

      //   name        sel    op      data_in       imm    reg_b         expected     N1  N4 hold
      issue("sll_imm",  2'b00, 3'b001, 32'h00000001, 5'd4,  32'h0,        32'h00000010, 4,  1, 1);
      issue("sra_regb", 2'b01, 3'b011, 32'h80000000, 5'd0,  32'hFFFFFFE4, 32'hF8000000, 4,  1, 1);
      issue("srl_regb", 2'b01, 3'b010, 32'h80000000, 5'd0,  32'hFFFFFFE4, 32'h08000000, 4,  1, 1);
      issue("ror_const",2'b10, 3'b101, 32'h12345678, 5'd0,  32'h0,        32'h34567812, 24, 6, 1);
      issue("zero_amt", 2'b00, 3'b001, 32'hDEADBEEF, 5'd0,  32'h0,        32'hDEADBEEF, 0,  0, 2);
      issue("sll_hold", 2'b00, 3'b001, 32'h00000001, 5'd4,  32'h0,        32'h00000010, 4,  1, 3);
      issue("rol_imm8", 2'b00, 3'b100, 32'h80000001, 5'd8,  32'h0,        32'h00000180, 8,  2, 1);
      issue("sra_imm6", 2'b00, 3'b011, 32'h80000F00, 5'd6,  32'h0,        32'hFE00003C, 6,  2, 1);
      issue("pass_op",  2'b00, 3'b000, 32'hCAFEF00D, 5'd5,  32'h0,        32'hCAFEF00D, 0,  0, 1);
      issue("op110",    2'b00, 3'b110, 32'h0F0F0000, 5'd5,  32'h0,        32'h0F0F0000, 0,  0, 1);
      issue("sll_31",   2'b00, 3'b001, 32'h00000001, 5'd31, 32'h0,        32'h80000000, 31, 8, 1);
      issue("srl_31",   2'b00, 3'b010, 32'h80000000, 5'd31, 32'h0,        32'h00000001, 31, 8, 1);
      issue("pre_abort",2'b00, 3'b001, 32'h00000001, 5'd4,  32'h0,        32'h00000010, 4,  1, 1);

      // Abort sampled on the third edge of an sll by 8.
      @(negedge clk);
      shamt_sel = 2'b00;
      shift_op  = 3'b001;
      data_in   = 32'h000000FF;
      imm_shamt = 5'd8;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort busy1", {31'd0, busy1}, 32'd0);
      chk("abort busy4", {31'd0, busy4}, 32'd0);
      chk("abort result1", result1, 32'h00000010);
      chk("abort result4", result4, 32'h00000010);
      repeat (12) @(negedge clk);

      // Abort together with start in IDLE drops the request.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start busy1", {31'd0, busy1}, 32'd0);
      chk("abort_start busy4", {31'd0, busy4}, 32'd0);
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of a long shift.
      start     = 1'b1;
      shift_op  = 3'b001;
      data_in   = 32'h00000003;
      imm_shamt = 5'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset busy1", {31'd0, busy1}, 32'd0);
      chk("midreset done1", {31'd0, done1}, 32'd0);
      chk("midreset result1", result1, 32'h0);
      chk("midreset busy4", {31'd0, busy4}, 32'd0);
      chk("midreset result4", result4, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("post reset busy1", {31'd0, busy1}, 32'd0);
      chk("post reset result1", result1, 32'h0);

      chk("pending step1", 32'(q1.size()), 32'd0);
      chk("pending step4", 32'(q4.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
